// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control encodings, op classes and the decoded control bundle
package alu_ctrl_pkg;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_XOR = 4'b1000;
   localparam logic [2:0] OP_I  = 3'b000;
   localparam logic [2:0] OP_R  = 3'b010;
   localparam logic [2:0] OP_LS = 3'b100;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MDU  = 7'b0000001;
   typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10} shtype_e;
   typedef enum logic [1:0] {EMPTY, WAIT, FULL} slot_e;
   typedef struct packed {
      logic [3:0] alucontrol;
      shtype_e    shtype;
      logic       alu2src;
      logic       sltunsigned;
      logic       lh;
      logic       lb;
      logic       lhu;
      logic       lbu;
      logic       word_op;
      logic       mdu_en;
      logic [2:0] mdu_op;
      logic       illegal;
   } alu_ctrl_t;
endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: decode request / decoded control handshake bundle
// master: decode+execute side (drives in_valid, op fields, out_ready)
// slave:  alu_ctrl_pipe (drives in_ready, out_valid and all control fields)
interface alu_ctrl_pipe_if;
   import alu_ctrl_pkg::*;
   logic       in_valid, in_ready, out_valid, out_ready, is_word;
   logic [2:0] aluop, funct3, mdu_op;
   logic [6:0] funct7;
   logic [3:0] alucontrol;
   shtype_e    shtype;
   logic       alu2src, sltunsigned, lh, lb, lhu, lbu, word_op, mdu_en, illegal;
   modport master(output in_valid, aluop, funct3, funct7, is_word, out_ready,
                  input in_ready, out_valid, alucontrol, shtype, alu2src, sltunsigned,
                  lh, lb, lhu, lbu, word_op, mdu_en, mdu_op, illegal);
   modport slave(input in_valid, aluop, funct3, funct7, is_word, out_ready,
                 output in_ready, out_valid, alucontrol, shtype, alu2src, sltunsigned,
                 lh, lb, lhu, lbu, word_op, mdu_en, mdu_op, illegal);
endinterface

// File: rtl/alu_ctrl_skid.sv
// alu_ctrl_skid: one-entry holding buffer for a decoded op (its mdu_en field is the MDU flag)
// ports: clk, reset (async active-low), push/d write, pop release, full/q current entry
module alu_ctrl_skid
   import alu_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  logic      pop,
   input  alu_ctrl_t d,
   output logic      full,
   output alu_ctrl_t q
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         full <= 1'b0;
         q <= '0;
      end else begin
         full <= push | (full & ~pop);
         if (push) q <= d;
      end
endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: pipelined ALU/shifter/load/MDU control decoder with valid/ready handshake
// ports: clk, reset (async active-low), bus (alu_ctrl_pipe_if.slave: request in, decoded controls out)
// params: XLEN (32/64, gates word ops and ld), MDU_LAT (1..15 cycles accept-to-valid for MDU ops)
// ALU_CTRL_MDU_EN: when defined, funct7=0000001 decodes to MDU ops held for MDU_LAT cycles;
// otherwise it is illegal and no latency counter exists.
module alu_ctrl_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MDU_LAT = 4
) (
   input logic            clk,
   input logic            reset,
   alu_ctrl_pipe_if.slave bus
);
   function automatic alu_ctrl_t decode(input logic [2:0] op, f3, input logic [6:0] f7, input logic w);
      alu_ctrl_t c;
      logic bad, wok;
      c = '0;
      bad = 1'b0;
      wok = 1'b0;
      if (op == OP_I || (op == OP_R && f7 == F7_BASE)) begin
         c.alucontrol = f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR : f3 == 3'b100 ? ALU_XOR :
                        f3[2:1] == 2'b01 ? ALU_SLT : ALU_ADD;
         c.sltunsigned = f3 == 3'b011;
         c.alu2src = f3[1:0] == 2'b01;
         c.shtype = f3 == 3'b101 ? (f7[5] ? SH_SRA : SH_SRL) : SH_SLL;
         // f7[0] is the RV64 shamt[5] bit, so only f7[6:1] must be zero for slli
         bad = f3 == 3'b001 && f7[6:1] != 6'd0;
         wok = f3 == 3'b000 || f3[1:0] == 2'b01;
      end else if (op == OP_R && f7 == F7_ALT) begin
         c.alucontrol = f3 == 3'b000 ? ALU_SUB : ALU_ADD;
         c.alu2src = f3 == 3'b101;
         c.shtype = f3 == 3'b101 ? SH_SRA : SH_SLL;
         bad = f3 != 3'b000 && f3 != 3'b101;
         wok = 1'b1;
      end
`ifdef ALU_CTRL_MDU_EN
      else if (op == OP_R && f7 == F7_MDU) begin
         c.mdu_en = 1'b1;
         c.mdu_op = f3;
         wok = f3 == 3'b000 || f3[2];
      end
`endif
      else if (op == OP_R) bad = 1'b1;
      else if (op == OP_LS) begin
         c.alucontrol = ALU_ADD;
         c.lb = f3 == 3'b000 || f3 == 3'b100;
         c.lh = f3 == 3'b001 || f3 == 3'b101;
         c.lbu = f3 == 3'b100;
         c.lhu = f3 == 3'b101;
         bad = f3[2:1] == 2'b11 || (f3 == 3'b011 && XLEN != 64);
      end
      if (w) begin
         bad = bad | !(XLEN == 64 && wok);
         c.word_op = 1'b1;
      end
      if (bad) begin
         c = '0;
         c.illegal = 1'b1;
      end
      return c;
   endfunction

   alu_ctrl_t dec, ld_d, out_q, skid_q;
   slot_e     state, nxt;
   logic      acc, drain, free, load, push, pop, skid_full, skid_nxt, rdy, go_wait, wait_done;

   assign dec = decode(bus.aluop, bus.funct3, bus.funct7, bus.is_word);
   assign acc = bus.in_valid & rdy;
   assign drain = state == FULL && bus.out_ready;
   assign free = state == EMPTY || drain;
   // the skid entry is older than the input, so it always refills the slot first
   assign pop = free & skid_full;
   assign load = pop | (free & acc);
   assign push = acc & ~(free & ~skid_full);
   assign ld_d = skid_full ? skid_q : dec;
   assign skid_nxt = push | (skid_full & ~pop);

   alu_ctrl_skid u_skid (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .d    (dec),
      .full (skid_full),
      .q    (skid_q)
   );

`ifdef ALU_CTRL_MDU_EN
   logic [3:0] cnt;
   assign go_wait = ld_d.mdu_en && MDU_LAT > 1;
   assign wait_done = state == WAIT && cnt == 4'd1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (load) cnt <= 4'(MDU_LAT - 1);
      else if (state == WAIT) cnt <= cnt - 4'd1;
`else
   assign go_wait = 1'b0;
   assign wait_done = 1'b0;
`endif

   always_comb nxt = load ? (go_wait ? WAIT : FULL) : drain ? EMPTY : wait_done ? FULL : state;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= EMPTY;
         rdy <= 1'b0;
         out_q <= '0;
      end else begin
         state <= nxt;
         rdy <= !(nxt != EMPTY && skid_nxt);
         if (load) out_q <= ld_d;
      end

   assign bus.in_ready = rdy;
   assign bus.out_valid = state == FULL;
   assign bus.alucontrol = out_q.alucontrol;
   assign bus.shtype = out_q.shtype;
   assign bus.alu2src = out_q.alu2src;
   assign bus.sltunsigned = out_q.sltunsigned;
   assign bus.lh = out_q.lh;
   assign bus.lb = out_q.lb;
   assign bus.lhu = out_q.lhu;
   assign bus.lbu = out_q.lbu;
   assign bus.word_op = out_q.word_op;
   assign bus.mdu_en = out_q.mdu_en;
   assign bus.mdu_op = out_q.mdu_op;
   assign bus.illegal = out_q.illegal;
endmodule
